// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for regfile_scoreboard: write, reserve, scrub control in; read data/pending/status out.
// Pure wiring; no timing or flow control of its own.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic             ctrl_writeEnable;
  logic [AW-1:0]    ctrl_writeReg;
  logic [WIDTH-1:0] data_writeReg;
  logic [AW-1:0]    ctrl_readRegA;
  logic [AW-1:0]    ctrl_readRegB;
  logic [WIDTH-1:0] data_readRegA;
  logic [WIDTH-1:0] data_readRegB;
  logic             ctrl_reserveEnable;
  logic [AW-1:0]    ctrl_reserveReg;
  logic             pending_readRegA;
  logic             pending_readRegB;
  logic             ctrl_clear;
  logic             clear_busy;
  logic             clear_done;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_reserveEnable, ctrl_reserveReg, ctrl_clear,
    input  data_readRegA, data_readRegB,
    input  pending_readRegA, pending_readRegB, clear_busy, clear_done
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_reserveEnable, ctrl_reserveReg, ctrl_clear,
    output data_readRegA, data_readRegB,
    output pending_readRegA, pending_readRegB, clear_busy, clear_done
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with optional write bypass, per-register pending bits and an NREGS-cycle scrub engine.
// Reads are combinational; no backpressure: writes/reserves during a scrub are dropped, not stalled.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                 clock,
  input logic                 ctrl_reset_n,
  regfile_scoreboard_if.slave rf
);
  typedef enum logic [1:0] {IDLE, SCRUB, DONE} state_t;

  localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic             clear_busy_q;
  logic             clear_done_q;

  logic accept;
  logic wr_ok;
  logic rs_ok;
  logic byp_a;
  logic byp_b;
  logic rs_hit_a;
  logic rs_hit_b;

  // Out-of-range addresses and the hardwired zero register are neither stored nor tracked.
  function automatic logic usable(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
  endfunction

  assign accept = (state != SCRUB);
  assign wr_ok  = accept && rf.ctrl_writeEnable   && usable(rf.ctrl_writeReg);
  assign rs_ok  = accept && rf.ctrl_reserveEnable && usable(rf.ctrl_reserveReg);

  assign byp_a    = BYPASS && wr_ok && (rf.ctrl_writeReg == rf.ctrl_readRegA);
  assign byp_b    = BYPASS && wr_ok && (rf.ctrl_writeReg == rf.ctrl_readRegB);
  assign rs_hit_a = rs_ok && (rf.ctrl_reserveReg == rf.ctrl_readRegA);
  assign rs_hit_b = rs_ok && (rf.ctrl_reserveReg == rf.ctrl_readRegB);

  assign rf.data_readRegA = !usable(rf.ctrl_readRegA) ? '0 :
                            byp_a ? rf.data_writeReg : regs[rf.ctrl_readRegA];
  assign rf.data_readRegB = !usable(rf.ctrl_readRegB) ? '0 :
                            byp_b ? rf.data_writeReg : regs[rf.ctrl_readRegB];

  // A completing producer hides the stale pending bit unless a newer producer issues alongside it.
  assign rf.pending_readRegA = usable(rf.ctrl_readRegA) && !(byp_a && !rs_hit_a) &&
                               pend[rf.ctrl_readRegA];
  assign rf.pending_readRegB = usable(rf.ctrl_readRegB) && !(byp_b && !rs_hit_b) &&
                               pend[rf.ctrl_readRegB];

  assign rf.clear_busy = clear_busy_q;
  assign rf.clear_done = clear_done_q;

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend         <= '0;
      state        <= IDLE;
      idx          <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (wr_ok) begin
            regs[rf.ctrl_writeReg] <= rf.data_writeReg;
            pend[rf.ctrl_writeReg] <= 1'b0;
          end
          if (rs_ok) pend[rf.ctrl_reserveReg] <= 1'b1;
          clear_done_q <= 1'b0;
          if (state == IDLE && rf.ctrl_clear) begin
            state        <= SCRUB;
            idx          <= '0;
            clear_busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SCRUB: begin
          regs[idx] <= '0;
          pend[idx] <= 1'b0;
          if (idx == LAST) begin
            state        <= DONE;
            idx          <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, scrub/reset sequences, variant builds,
// and a randomized run against an array-based reference model of the default build.
module tb_regfile_scoreboard;
  logic clock;
  logic rst_n;

  regfile_scoreboard_if #(.WIDTH(32), .NREGS(32)) if_d ();
  regfile_scoreboard_if #(.WIDTH(32), .NREGS(32)) if_n ();
  regfile_scoreboard_if #(.WIDTH(16), .NREGS(24)) if_s ();

  regfile_scoreboard u_dut (.clock(clock), .ctrl_reset_n(rst_n), .rf(if_d));
  regfile_scoreboard #(.BYPASS(1'b0)) u_nb (.clock(clock), .ctrl_reset_n(rst_n), .rf(if_n));
  regfile_scoreboard #(.WIDTH(16), .NREGS(24)) u_sm (.clock(clock), .ctrl_reset_n(rst_n), .rf(if_s));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model of the default build: register contents, pending flags, scrub progress.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_busy;
  bit          m_done;
  int          m_pos;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rs;
    logic [4:0]  rr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        epa;
    logic        epb;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit was_done;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_done = 1'b0;
      m_pos  = 0;
    end else if (m_busy) begin
      m_regs[m_pos] = '0;
      m_pend[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == 32) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (if_d.ctrl_writeEnable && if_d.ctrl_writeReg != 0) begin
        m_regs[if_d.ctrl_writeReg] = if_d.data_writeReg;
        m_pend[if_d.ctrl_writeReg] = 1'b0;
      end
      if (if_d.ctrl_reserveEnable && if_d.ctrl_reserveReg != 0) m_pend[if_d.ctrl_reserveReg] = 1'b1;
      if (!was_done && if_d.ctrl_clear) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (!m_busy && if_d.ctrl_writeEnable && if_d.ctrl_writeReg == a) return if_d.data_writeReg;
    return m_regs[a];
  endfunction

  function automatic logic m_pending(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (!m_busy && if_d.ctrl_writeEnable && if_d.ctrl_writeReg == a &&
        !(if_d.ctrl_reserveEnable && if_d.ctrl_reserveReg == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_all();
    if_d.ctrl_writeEnable = 0; if_d.ctrl_writeReg = 0; if_d.data_writeReg = 0;
    if_d.ctrl_readRegA = 0; if_d.ctrl_readRegB = 0;
    if_d.ctrl_reserveEnable = 0; if_d.ctrl_reserveReg = 0; if_d.ctrl_clear = 0;
    if_n.ctrl_writeEnable = 0; if_n.ctrl_writeReg = 0; if_n.data_writeReg = 0;
    if_n.ctrl_readRegA = 0; if_n.ctrl_readRegB = 0;
    if_n.ctrl_reserveEnable = 0; if_n.ctrl_reserveReg = 0; if_n.ctrl_clear = 0;
    if_s.ctrl_writeEnable = 0; if_s.ctrl_writeReg = 0; if_s.data_writeReg = 0;
    if_s.ctrl_readRegA = 0; if_s.ctrl_readRegB = 0;
    if_s.ctrl_reserveEnable = 0; if_s.ctrl_reserveReg = 0; if_s.ctrl_clear = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      if_d.ctrl_readRegA = 5'(r);
      #1;
      chk($sformatf("%s_reg%0d", tag, r), if_d.data_readRegA, 32'h0);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    vt[0] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h12345678, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h12345678, 1'b0, 1'b0};
    vt[3] = '{1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    vt[5] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd3, 5'd3, 32'h11, 32'h11, 1'b1, 1'b1};
    vt[6] = '{1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd3, 32'hA5, 32'hA5, 1'b0, 1'b0};
    vt[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hA5, 32'hA5, 1'b0, 1'b0};
    vt[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h12345678, 1'b0, 1'b0};
    vt[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};

    idle_all();
    rst_n = 1'b0;
    #2;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Reset state
    if_d.ctrl_readRegA = 5'd5; if_d.ctrl_readRegB = 5'd31;
    #1;
    chk("rst_busy", 32'(if_d.clear_busy), 32'h0);
    chk("rst_done", 32'(if_d.clear_done), 32'h0);
    chk("rst_rd_a", if_d.data_readRegA, 32'h0);
    chk("rst_rd_b", if_d.data_readRegB, 32'h0);
    chk("rst_pend_a", 32'(if_d.pending_readRegA), 32'h0);

    // Directed vector table: outputs sampled before the edge that commits the inputs
    for (int i = 0; i < 10; i++) begin
      if_d.ctrl_writeEnable = vt[i].we; if_d.ctrl_writeReg = vt[i].wa; if_d.data_writeReg = vt[i].wd;
      if_d.ctrl_reserveEnable = vt[i].rs; if_d.ctrl_reserveReg = vt[i].rr;
      if_d.ctrl_readRegA = vt[i].ra; if_d.ctrl_readRegB = vt[i].rb;
      #1;
      chk($sformatf("vec%0d_rd_a", i), if_d.data_readRegA, vt[i].ea);
      chk($sformatf("vec%0d_rd_b", i), if_d.data_readRegB, vt[i].eb);
      chk($sformatf("vec%0d_pend_a", i), 32'(if_d.pending_readRegA), 32'(vt[i].epa));
      chk($sformatf("vec%0d_pend_b", i), 32'(if_d.pending_readRegB), 32'(vt[i].epb));
      cyc();
    end
    idle_all();

    // No-bypass build returns the old value until the write edge
    if_n.ctrl_writeEnable = 1; if_n.ctrl_writeReg = 5'd7; if_n.data_writeReg = 32'hCAFEF00D;
    if_n.ctrl_readRegA = 5'd7; if_n.ctrl_readRegB = 5'd7;
    #1;
    chk("nobyp_rd_a", if_n.data_readRegA, 32'h0);
    chk("nobyp_rd_b", if_n.data_readRegB, 32'h0);
    cyc();
    if_n.ctrl_writeEnable = 0;
    #1;
    chk("nobyp_after_a", if_n.data_readRegA, 32'hCAFEF00D);

    // Non-power-of-two build: out-of-range address neither stores nor reads
    if_s.ctrl_writeEnable = 1; if_s.ctrl_writeReg = 5'd30; if_s.data_writeReg = 32'h0000BEEF;
    if_s.ctrl_reserveEnable = 1; if_s.ctrl_reserveReg = 5'd30;
    if_s.ctrl_readRegA = 5'd30;
    #1;
    chk("small_oob_byp", 32'(if_s.data_readRegA), 32'h0);
    cyc();
    if_s.ctrl_writeReg = 5'd23; if_s.data_writeReg = 32'h00001234; if_s.ctrl_reserveEnable = 0;
    cyc();
    if_s.ctrl_writeEnable = 0; if_s.ctrl_readRegB = 5'd23;
    #1;
    chk("small_oob_rd", 32'(if_s.data_readRegA), 32'h0);
    chk("small_oob_pend", 32'(if_s.pending_readRegA), 32'h0);
    chk("small_last_rd", 32'(if_s.data_readRegB), 32'h1234);
    if_s.ctrl_clear = 1;
    cyc();
    if_s.ctrl_clear = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (if_s.clear_busy) busy_cnt++;
      if (if_s.clear_done) begin done_cnt++; done_at = k; end
      cyc();
    end
    chk("small_busy_cycles", 32'(busy_cnt), 32'd24);
    chk("small_done_cnt", 32'(done_cnt), 32'd1);
    chk("small_done_at", 32'(done_at), 32'd24);
    chk("small_scrubbed", 32'(if_s.data_readRegB), 32'h0);

    // Scrub of a full file with a pending register
    for (int r = 1; r < 32; r++) begin
      if_d.ctrl_writeEnable = 1; if_d.ctrl_writeReg = 5'(r); if_d.data_writeReg = 32'(r);
      cyc();
    end
    if_d.ctrl_writeEnable = 0;
    if_d.ctrl_reserveEnable = 1; if_d.ctrl_reserveReg = 5'd9;
    cyc();
    if_d.ctrl_reserveEnable = 0; if_d.ctrl_readRegA = 5'd9; if_d.ctrl_readRegB = 5'd17;
    #1;
    chk("fill_pend9", 32'(if_d.pending_readRegA), 32'h1);
    chk("fill_rd17", if_d.data_readRegB, 32'd17);
    if_d.ctrl_clear = 1;
    cyc();
    if_d.ctrl_clear = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if_d.ctrl_writeEnable = (k == 5);
      if_d.ctrl_writeReg = 5'd4; if_d.data_writeReg = 32'h44444444;
      if_d.ctrl_readRegB = 5'd4;
      #1;
      if (k == 5) chk("scrub_no_bypass", if_d.data_readRegB, 32'h0);
      if (if_d.clear_busy) busy_cnt++;
      if (if_d.clear_done) begin done_cnt++; done_at = k; end
      cyc();
    end
    if_d.ctrl_writeEnable = 0;
    chk("scrub_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("scrub_done_cnt", 32'(done_cnt), 32'd1);
    chk("scrub_done_at", 32'(done_at), 32'd32);
    if_d.ctrl_readRegB = 5'd9;
    #1;
    chk("scrub_pend9", 32'(if_d.pending_readRegB), 32'h0);
    check_all_zero("scrub");

    // Reset in the middle of a scrub abandons it
    for (int r = 20; r < 26; r++) begin
      if_d.ctrl_writeEnable = 1; if_d.ctrl_writeReg = 5'(r); if_d.data_writeReg = 32'hF0 + 32'(r);
      cyc();
    end
    if_d.ctrl_writeEnable = 0;
    if_d.ctrl_clear = 1;
    cyc();
    if_d.ctrl_clear = 0;
    for (int k = 0; k < 10; k++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", 32'(if_d.clear_busy), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (if_d.clear_done) done_cnt++;
      cyc();
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    check_all_zero("midrst");
    if_d.ctrl_clear = 1;
    cyc();
    if_d.ctrl_clear = 0;
    #1;
    chk("midrst_restart", 32'(if_d.clear_busy), 32'h1);
    for (int k = 0; k < 34; k++) cyc();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if_d.ctrl_writeEnable   = ($urandom_range(0, 1) == 1);
      if_d.ctrl_writeReg      = 5'($urandom_range(0, 7));
      if_d.data_writeReg      = $urandom;
      if_d.ctrl_reserveEnable = ($urandom_range(0, 3) == 0);
      if_d.ctrl_reserveReg    = 5'($urandom_range(0, 7));
      if_d.ctrl_readRegA      = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if_d.ctrl_readRegB      = 5'($urandom_range(0, 7));
      if_d.ctrl_clear         = ($urandom_range(0, 149) == 0);
      #1;
      chk("rand_rd_a", if_d.data_readRegA, m_read(if_d.ctrl_readRegA));
      chk("rand_rd_b", if_d.data_readRegB, m_read(if_d.ctrl_readRegB));
      chk("rand_pend_a", 32'(if_d.pending_readRegA), 32'(m_pending(if_d.ctrl_readRegA)));
      chk("rand_pend_b", 32'(if_d.pending_readRegB), 32'(m_pending(if_d.ctrl_readRegB)));
      chk("rand_busy", 32'(if_d.clear_busy), 32'(m_busy));
      chk("rand_done", 32'(if_d.clear_done), 32'(m_done));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
